strait_bist_ctrl: RTL and testbench
===================================

STRAIT_BIST_CTRL -- requirements
Module: strait_bist_ctrl

Interface
Parameters:
REQ-001 SHALL have parameter N_PE, default 4: PEs in the P scan chain, 1..64.
REQ-002 SHALL have parameter N_PAT, default 8: patterns per run, 1..255.
REQ-003 SHALL have parameter CAP_CYC, default 2: capture cycles per pattern, 1..15.
REQ-004 SHALL have parameters SEED, default 32'h0000_0001 (LFSR seed, non-zero), and GOLDEN, default 32'h0000_0000 (expected final MISR signature).

Ports (name  direction  width  meaning):
REQ-005 SHALL have clk  in  1  single clock, rising edge.
REQ-006 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have start  in  1  begin a run; sampled only in IDLE.
REQ-008 SHALL have scan_en  out  1  PE-chain mode: 1 = shift, 0 = capture.
REQ-009 SHALL have a_out, w_out  out  32  PE A and W operands.
REQ-010 SHALL have p_in  out  32  word into the head of the chain.
REQ-011 SHALL have p_out  in  32  word from the tail of the chain.
REQ-012 SHALL have busy, done, pass  out  1  status signals.
REQ-013 SHALL have pat_cnt  out  8  index of the current pattern.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CAPTURE, UNLOAD, COMPARE, DONE.
REQ-015 SHALL move IDLE->LOAD on the edge where start=1, clearing lfsr to SEED, misr to 0, pat_cnt to 0 and pass to 0.
REQ-016 SHALL stay in LOAD for N_PE cycles with scan_en=1 and p_in=lfsr, advancing lfsr every LOAD cycle.
REQ-017 SHALL stay in CAPTURE for CAP_CYC cycles with scan_en=0, p_in=0, a_out=lfsr and w_out={lfsr[15:0],lfsr[31:16]}, holding all of them constant; lfsr advances once, on the edge leaving CAPTURE.
REQ-018 SHALL stay in UNLOAD for N_PE cycles with scan_en=1 and p_in=0, absorbing p_out into misr on every UNLOAD edge, the first at the edge ending UNLOAD cycle 0.
REQ-019 SHALL compute the LFSR step as next = {l[30:0],1'b0} ^ (l[31] ? 32'h8020_0003 : 0).
REQ-020 SHALL compute the MISR step as next = {m[30:0],1'b0} ^ (m[31] ? 32'h8020_0003 : 0) ^ p_out.
REQ-021 SHALL, leaving UNLOAD, go to LOAD with pat_cnt+1 if pat_cnt<N_PAT-1, else to COMPARE.
REQ-022 SHALL, in COMPARE (1 cycle), register pass = (misr==GOLDEN) and then go to DONE.
REQ-023 SHALL, in DONE (1 cycle), drive done=1 and then go to IDLE; pass SHALL hold until the next accepted start.
REQ-024 SHALL drive busy=1 exactly in LOAD, CAPTURE, UNLOAD and COMPARE.
REQ-025 SHALL ignore start outside IDLE, including in DONE.
REQ-026 SHALL give a run duration of N_PAT*(2*N_PE+CAP_CYC)+1 busy cycles, with done in the following cycle.
REQ-027 SHALL, in IDLE and DONE, drive scan_en=0, a_out=0, w_out=0 and p_in=0.
REQ-028 SHALL use internal cycle counters wide enough for max N_PE and CAP_CYC, with no wrap inside a state.

Reset
REQ-029 SHALL, while rst=1, immediately force state=IDLE, scan_en=0, a_out=w_out=p_in=0, busy=done=pass=0, pat_cnt=0, lfsr=SEED and misr=0.
REQ-030 SHALL abandon a run when rst is asserted mid-run: no done pulse, pass=0, and a new start after release begins a fresh run.

Verification
REQ-031 SHALL cover reset: assert rst at any time -> all outputs 0 in the same cycle, with no clock edge needed.
REQ-032 SHALL cover single-pattern golden: N_PE=1, N_PAT=1, CAP_CYC=2, GOLDEN=32'h0004_0000, chain = one PE_Top_STRAIT; start at edge 0 -> p_in=1 in cycle 1; a_out=2, w_out=32'h0002_0000 in cycles 2-3; UNLOAD in cycle 4; COMPARE in cycle 5; done=1 and pass=1 in cycle 6.
REQ-033 SHALL cover mismatch: same setup with a faulty PE model (P forced 0) -> done=1 in cycle 6, pass=0.
REQ-034 SHALL cover multi-pattern: N_PE=4, N_PAT=8, CAP_CYC=2 against a behavioural chain model -> busy for exactly 81 cycles, pat_cnt steps 0..7, scan_en low in exactly 16 cycles, pass matches the model's MISR.
REQ-035 SHALL cover start while busy: pulse start in LOAD, CAPTURE and DONE -> run timing unchanged, no second run.
REQ-036 SHALL cover reset mid-CAPTURE: assert rst in cycle 3 of REQ-032, release, then start -> identical waveform to REQ-032 and pass=1.

Source files
------------

// File: rtl/strait_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : strait_bist_ctrl
//  Purpose  : Built-in self-test sequencer for a STRAIT PE scan chain.
//             Each pattern shifts N_PE LFSR words into the P chain (LOAD),
//             applies LFSR-derived A/W operands with the chain in capture
//             mode (CAPTURE), then shifts the chain out into a MISR
//             (UNLOAD). After N_PAT patterns the MISR is compared against
//             GOLDEN (COMPARE) and a one-cycle done pulse is issued (DONE).
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-high reset
//             start    - begin a run (honoured only in IDLE)
//             scan_en  - chain mode, 1 = shift, 0 = capture
//             a_out    - PE A operand
//             w_out    - PE W operand
//             p_in     - word into the chain head
//             p_out    - word from the chain tail
//             busy     - run in progress (LOAD..COMPARE)
//             done     - one-cycle end-of-run pulse
//             pass     - final signature matched GOLDEN
//             pat_cnt  - index of the current pattern
//  Revision : 1.0 - initial release
// ============================================================================
module strait_bist_ctrl #(
   parameter int          N_PE    = 4,
   parameter int          N_PAT   = 8,
   parameter int          CAP_CYC = 2,
   parameter logic [31:0] SEED    = 32'h0000_0001,
   parameter logic [31:0] GOLDEN  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        scan_en,
   output logic [31:0] a_out,
   output logic [31:0] w_out,
   output logic [31:0] p_in,
   input  logic [31:0] p_out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  pat_cnt
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_UNLOAD  = 3'd3;
   localparam logic [2:0] S_COMPARE = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [31:0] c_poly     = 32'h8020_0003;
   // 7 bits covers the largest in-state count (N_PE up to 64) without wrap.
   localparam logic [6:0]  c_pe_last  = 7'(N_PE - 1);
   localparam logic [6:0]  c_cap_last = 7'(CAP_CYC - 1);
   localparam logic [7:0]  c_pat_last = 8'(N_PAT - 1);

   logic [2:0]  r_state;
   logic [2:0]  w_next_state;
   logic [6:0]  r_cyc;
   logic [31:0] r_lfsr;
   logic [31:0] r_misr;
   logic [7:0]  r_pat;
   logic        r_pass;

   function automatic logic [31:0] f_lfsr_step(input logic [31:0] l);
      f_lfsr_step = {l[30:0], 1'b0} ^ (l[31] ? c_poly : 32'h0);
   endfunction

   function automatic logic [31:0] f_misr_step(input logic [31:0] m, input logic [31:0] d);
      f_misr_step = {m[30:0], 1'b0} ^ (m[31] ? c_poly : 32'h0) ^ d;
   endfunction

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next_state = S_LOAD;
         S_LOAD:    if (r_cyc == c_pe_last) w_next_state = S_CAPTURE;
         S_CAPTURE: if (r_cyc == c_cap_last) w_next_state = S_UNLOAD;
         S_UNLOAD: begin
            if (r_cyc == c_pe_last) begin
               w_next_state = (r_pat == c_pat_last) ? S_COMPARE : S_LOAD;
            end
         end
         S_COMPARE: w_next_state = S_DONE;
         S_DONE:    w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc  <= 7'd0;
         r_lfsr <= SEED;
         r_misr <= 32'h0;
         r_pat  <= 8'd0;
         r_pass <= 1'b0;
      end else begin
         // In-state cycle counter restarts on every state change, so a
         // back-to-back UNLOAD->LOAD also begins LOAD at cycle 0.
         if (w_next_state != r_state) begin
            r_cyc <= 7'd0;
         end else if (r_state == S_LOAD || r_state == S_CAPTURE || r_state == S_UNLOAD) begin
            r_cyc <= r_cyc + 7'd1;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_lfsr <= SEED;
                  r_misr <= 32'h0;
                  r_pat  <= 8'd0;
                  r_pass <= 1'b0;
               end
            end
            S_LOAD: begin
               r_lfsr <= f_lfsr_step(r_lfsr);
            end
            S_CAPTURE: begin
               // Operands stay frozen for the whole capture window.
               if (r_cyc == c_cap_last) r_lfsr <= f_lfsr_step(r_lfsr);
            end
            S_UNLOAD: begin
               r_misr <= f_misr_step(r_misr, p_out);
               if (r_cyc == c_pe_last && r_pat != c_pat_last) r_pat <= r_pat + 8'd1;
            end
            S_COMPARE: begin
               r_pass <= (r_misr == GOLDEN);
            end
            default: ;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      scan_en = 1'b0;
      p_in    = 32'h0;
      a_out   = 32'h0;
      w_out   = 32'h0;
      case (r_state)
         S_LOAD: begin
            busy    = 1'b1;
            scan_en = 1'b1;
            p_in    = r_lfsr;
         end
         S_CAPTURE: begin
            busy  = 1'b1;
            a_out = r_lfsr;
            w_out = {r_lfsr[15:0], r_lfsr[31:16]};
         end
         S_UNLOAD: begin
            busy    = 1'b1;
            scan_en = 1'b1;
         end
         S_COMPARE: begin
            // Chain is left in shift mode so capture happens only in CAPTURE.
            busy    = 1'b1;
            scan_en = 1'b1;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign pass    = r_pass;
   assign pat_cnt = r_pat;

endmodule
`default_nettype wire

// File: tb/tb_strait_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strait_bist_ctrl
//  Purpose  : Self-checking bench for strait_bist_ctrl. A single-PE instance
//             checks exact cycle timing against a known golden signature;
//             a four-PE instance runs eight patterns against a behavioural
//             chain and a transaction-level reference of the whole run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_strait_bist_ctrl;

   typedef struct {
      logic        pass;
      int          busy_n;
      int          low_n;
   } exp_t;

   logic clk;
   logic rst;
   logic start1, start4;
   logic fault;

   logic        s1_scan, s1_busy, s1_done, s1_pass;
   logic [31:0] s1_a, s1_w, s1_pin, s1_pout;
   logic [7:0]  s1_pat;
   logic        s4_scan, s4_busy, s4_done, s4_pass;
   logic [31:0] s4_a, s4_w, s4_pin, s4_pout;
   logic [7:0]  s4_pat;

   int n_cmp;
   int n_bad;

   exp_t        sb1[$];
   exp_t        sb4[$];
   logic [31:0] exp_pin_q[$];
   logic [31:0] exp_a_q[$];

   strait_bist_ctrl #(
      .N_PE(1), .N_PAT(1), .CAP_CYC(2), .SEED(32'h0000_0001), .GOLDEN(32'h0004_0000)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start1), .scan_en(s1_scan), .a_out(s1_a),
      .w_out(s1_w), .p_in(s1_pin), .p_out(s1_pout), .busy(s1_busy),
      .done(s1_done), .pass(s1_pass), .pat_cnt(s1_pat)
   );

   strait_bist_ctrl #(
      .N_PE(4), .N_PAT(8), .CAP_CYC(2), .SEED(32'h0000_0001), .GOLDEN(32'h0000_0000)
   ) dut4 (
      .clk(clk), .rst(rst), .start(start4), .scan_en(s4_scan), .a_out(s4_a),
      .w_out(s4_w), .p_in(s4_pin), .p_out(s4_pout), .busy(s4_busy),
      .done(s4_done), .pass(s4_pass), .pat_cnt(s4_pat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural PE chains: shift when scan_en=1, else P <= A*W.
   logic [31:0] ch1;
   logic [31:0] ch4 [4];
   always_ff @(posedge clk) begin
      if (s1_scan) ch1 <= s1_pin;
      else         ch1 <= s1_a * s1_w;
      if (s4_scan) begin
         ch4[0] <= s4_pin;
         for (int k = 1; k < 4; k++) ch4[k] <= ch4[k-1];
      end else begin
         for (int k = 0; k < 4; k++) ch4[k] <= s4_a * s4_w;
      end
   end
   assign s1_pout = fault ? 32'h0 : ch1;
   assign s4_pout = ch4[3];

   function automatic logic [31:0] lfsr_step(input logic [31:0] l);
      lfsr_step = {l[30:0], 1'b0} ^ (l[31] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] m, input logic [31:0] d);
      misr_step = {m[30:0], 1'b0} ^ (m[31] ? 32'h8020_0003 : 32'h0) ^ d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl1"}, {28'h0, s1_scan, s1_busy, s1_done, s1_pass}, 32'h0);
      chk({tag, "_dat1"}, s1_a | s1_w | s1_pin | {24'h0, s1_pat}, 32'h0);
      chk({tag, "_ctl4"}, {28'h0, s4_scan, s4_busy, s4_done, s4_pass}, 32'h0);
      chk({tag, "_dat4"}, s4_a | s4_w | s4_pin | {24'h0, s4_pat}, 32'h0);
   endtask

   // Transaction-level reference of a full four-PE, eight-pattern run.
   task automatic ref_run(output logic [31:0] misr);
      logic [31:0] l, a, w;
      logic [31:0] p [4];
      l = 32'h0000_0001;
      misr = 32'h0;
      for (int k = 0; k < 4; k++) p[k] = 32'h0;
      exp_pin_q.delete();
      exp_a_q.delete();
      for (int pat = 0; pat < 8; pat++) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 3; k > 0; k--) p[k] = p[k-1];
            p[0] = l;
            exp_pin_q.push_back(l);
            l = lfsr_step(l);
         end
         exp_a_q.push_back(l);
         a = l;
         w = {l[15:0], l[31:16]};
         for (int k = 0; k < 4; k++) p[k] = a * w;
         l = lfsr_step(l);
         for (int i = 0; i < 4; i++) begin
            misr = misr_step(misr, p[3]);
            for (int k = 3; k > 0; k--) p[k] = p[k-1];
            p[0] = 32'h0;
         end
      end
   endtask

   // Single-PE run: start at edge 0, checks cycles 1..8 against fixed timing.
   task automatic run_dut1(input logic flt, input logic pulse_busy);
      logic [2:0]  e_ctl [1:8];
      logic [31:0] e_pin [1:8];
      logic [31:0] e_a   [1:8];
      logic [31:0] e_w   [1:8];
      exp_t        e, got;
      //        scan busy done
      e_ctl[1] = 3'b110; e_pin[1] = 32'h1; e_a[1] = 32'h0; e_w[1] = 32'h0;
      e_ctl[2] = 3'b010; e_pin[2] = 32'h0; e_a[2] = 32'h2; e_w[2] = 32'h0002_0000;
      e_ctl[3] = 3'b010; e_pin[3] = 32'h0; e_a[3] = 32'h2; e_w[3] = 32'h0002_0000;
      e_ctl[4] = 3'b110; e_pin[4] = 32'h0; e_a[4] = 32'h0; e_w[4] = 32'h0;
      e_ctl[5] = 3'b110; e_pin[5] = 32'h0; e_a[5] = 32'h0; e_w[5] = 32'h0;
      e_ctl[6] = 3'b001; e_pin[6] = 32'h0; e_a[6] = 32'h0; e_w[6] = 32'h0;
      e_ctl[7] = 3'b000; e_pin[7] = 32'h0; e_a[7] = 32'h0; e_w[7] = 32'h0;
      e_ctl[8] = 3'b000; e_pin[8] = 32'h0; e_a[8] = 32'h0; e_w[8] = 32'h0;
      fault = flt;
      e.pass = ~flt; e.busy_n = 5; e.low_n = 2;
      sb1.push_back(e);
      start1 = 1'b1;
      tick;
      chk("r1_pass_clr", {31'h0, s1_pass}, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         start1 = (pulse_busy && (c == 1 || c == 2 || c == 6)) ? 1'b1 : 1'b0;
         chk($sformatf("r1_c%0d_ctl", c), {29'h0, s1_scan, s1_busy, s1_done}, {29'h0, e_ctl[c]});
         chk($sformatf("r1_c%0d_pin", c), s1_pin, e_pin[c]);
         chk($sformatf("r1_c%0d_a", c), s1_a, e_a[c]);
         chk($sformatf("r1_c%0d_w", c), s1_w, e_w[c]);
         if (s1_done && sb1.size() > 0) begin
            got = sb1.pop_front();
            chk("r1_pass", {31'h0, s1_pass}, {31'h0, got.pass});
         end
         if (c >= 7) chk($sformatf("r1_c%0d_hold", c), {31'h0, s1_pass}, {31'h0, ~flt});
         tick;
      end
      start1 = 1'b0;
      chk("r1_sb_left", sb1.size(), 32'h0);
      sb1.delete();
   endtask

   task automatic reset_mid_capture;
      exp_t e;
      e.pass = 1'b1; e.busy_n = 5; e.low_n = 2;
      fault = 1'b0;
      sb1.push_back(e);
      start1 = 1'b1;
      tick;
      start1 = 1'b0;
      tick;
      tick;
      chk("rmc_in_cap", {31'h0, s1_scan}, 32'h0);
      rst = 1'b1;
      #1;
      chk_zero("rmc_async");
      tick;
      rst = 1'b0;
      sb1.delete();  // abandoned run produces no result
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("rmc_idle%0d", c), {29'h0, s1_busy, s1_done, s1_pass}, 32'h0);
         tick;
      end
      run_dut1(1'b0, 1'b0);
   endtask

   task automatic run_dut4;
      exp_t        e, got;
      logic [31:0] misr;
      logic [31:0] exp_v;
      logic [7:0]  prev_pat;
      logic        in_cap;
      logic        seen_done;
      int          busy_n, low_n, steps;
      ref_run(misr);
      e.pass = (misr == 32'h0); e.busy_n = 81; e.low_n = 16;
      sb4.push_back(e);
      busy_n = 0; low_n = 0; steps = 0; in_cap = 1'b0; seen_done = 1'b0;
      start4 = 1'b1;
      tick;
      start4 = 1'b0;
      chk("r4_pat0", {24'h0, s4_pat}, 32'h0);
      prev_pat = s4_pat;
      for (int c = 0; c < 300 && !seen_done; c++) begin
         if (s4_busy) busy_n++;
         if (s4_busy && !s4_scan) low_n++;
         if (s4_pat != prev_pat) begin
            chk("r4_pat_step", {24'h0, s4_pat}, {24'h0, prev_pat + 8'd1});
            steps++;
            prev_pat = s4_pat;
         end
         if (s4_busy && s4_scan && s4_pin != 32'h0) begin
            exp_v = (exp_pin_q.size() > 0) ? exp_pin_q.pop_front() : 32'hDEAD_BEEF;
            chk("r4_pin", s4_pin, exp_v);
         end
         if (s4_busy && !s4_scan) begin
            exp_v = (exp_a_q.size() > 0) ? exp_a_q[0] : 32'hDEAD_BEEF;
            chk("r4_a", s4_a, exp_v);
            chk("r4_w", s4_w, {exp_v[15:0], exp_v[31:16]});
            in_cap = 1'b1;
         end else if (in_cap) begin
            if (exp_a_q.size() > 0) void'(exp_a_q.pop_front());
            in_cap = 1'b0;
         end
         if (s4_done) begin
            seen_done = 1'b1;
            got = sb4.pop_front();
            chk("r4_pass", {31'h0, s4_pass}, {31'h0, got.pass});
            chk("r4_busy_n", busy_n, got.busy_n);
            chk("r4_low_n", low_n, got.low_n);
            chk("r4_steps", steps, 32'd7);
            chk("r4_pat_last", {24'h0, s4_pat}, 32'd7);
         end
         tick;
      end
      if (!seen_done) chk("r4_timeout", 32'd1, 32'd0);
      chk("r4_pin_left", exp_pin_q.size(), 32'h0);
      chk("r4_a_left", exp_a_q.size(), 32'h0);
      chk("r4_idle", {31'h0, s4_busy}, 32'h0);
      sb4.delete();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      start1 = 1'b0;
      start4 = 1'b0;
      fault = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk_zero("rst_async");
      tick;
      tick;
      rst = 1'b0;
      tick;
      chk_zero("rst_idle");

      run_dut1(1'b0, 1'b0);   // golden signature
      run_dut1(1'b1, 1'b0);   // faulty PE -> mismatch
      run_dut1(1'b0, 1'b1);   // start pulses in LOAD/CAPTURE/DONE ignored
      reset_mid_capture();
      run_dut4();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
